l2_fetch_responder: RTL and testbench
=====================================

// Module: l2_fetch_responder
// PURPOSE
//  Consumer end of the instruction-fetch request path. Pops PC addresses from the fetch
//  queue (FWFT, 1-clk latency), issues one line read to the L2/memory side, assembles
//  BEATS returned data beats into a full cache line and hands that line back to the L1
//  refill path. Exactly one miss is outstanding at a time.
// PARAMETERS
//  ADDR_WIDTH  32  byte address width of fetch requests
//  DATA_WIDTH  32  width of one read-return beat
//  BEATS        4  beats per line; power of 2, >= 2; LINE_WIDTH = DATA_WIDTH*BEATS
// PORTS
//  CLK            in   1             clock, all logic on posedge
//  RST            in   1             synchronous, active-high reset
//  FQ_EMPTY       in   1             fetch queue EMPTY
//  FQ_ADDR        in   ADDR_WIDTH    fetch queue DATA_OUT (head PC)
//  FQ_POP         out  1             to fetch queue BOT_READY; pops head
//  MEM_REQ_VALID  out  1             read request valid
//  MEM_REQ_READY  in   1             read request accepted
//  MEM_REQ_ADDR   out  ADDR_WIDTH    read request address
//  MEM_RD_VALID   in   1             return beat valid (no backpressure)
//  MEM_RD_DATA    in   DATA_WIDTH    return beat data
//  LINE_VALID     out  1             assembled line valid
//  LINE_READY     in   1             L1 accepts line
//  LINE_ADDR      out  ADDR_WIDTH    line-aligned address of LINE_DATA
//  LINE_DATA      out  LINE_WIDTH    line; beat k in bits [k*DATA_WIDTH +: DATA_WIDTH]
//  BUSY           out  1             high in any state other than IDLE
// BEHAVIOUR
//  FSM IDLE -> REQ -> COLLECT -> RESP -> IDLE; 2-bit state, beat counter log2(BEATS) bits.
//  Reset: state IDLE, beat count 0, FQ_POP/MEM_REQ_VALID/LINE_VALID/BUSY 0,
//   MEM_REQ_ADDR, LINE_ADDR, LINE_DATA all zero.
//  IDLE: FQ_POP = !FQ_EMPTY (combinational, this state only); on pop latch FQ_ADDR, -> REQ.
//  REQ: MEM_REQ_VALID=1, address held stable until MEM_REQ_VALID&MEM_REQ_READY; -> COLLECT.
//   Latency: FQ_EMPTY low in IDLE -> MEM_REQ_VALID next cycle.
//  COLLECT: each MEM_RD_VALID writes beat into slot (start+cnt) mod BEATS, cnt++;
//   slot index wraps modulo BEATS; after BEATS-th beat -> RESP next cycle.
//  RESP: LINE_VALID=1; LINE_ADDR/LINE_DATA stable until LINE_VALID&LINE_READY; -> IDLE.
//   No pop in RESP: minimum one IDLE cycle between lines.
//  MEM_RD_VALID outside COLLECT is ignored (no state or data change).
//  LINE_READY outside RESP ignored; MEM_REQ_READY outside REQ ignored.
//  RST mid-operation: abandons in-flight miss, returns to IDLE, popped address is lost
//   (owner flushes queue alongside); stale beats arriving afterwards are ignored.
//  LINE_ADDR = latched addr with low log2(BEATS*DATA_WIDTH/8) bits cleared.
// CONFIGURATION
//  CRITICAL_WORD_FIRST_EN defined: MEM_REQ_ADDR = latched addr aligned to DATA_WIDTH
//   only; memory returns beats wrapping from requested word; start = word index of addr.
//  Undefined: MEM_REQ_ADDR = LINE_ADDR; beats return in order, start = 0.
//  LINE_DATA slot layout is identical in both builds.
// STRUCTURE
//  Shared package/header: FSM state encodings, LINE_WIDTH, OFFSET_BITS = log2(line bytes),
//   WORD_BITS = log2(DATA_WIDTH/8), BEAT_IDX_BITS = log2(BEATS).
//  One sub-module: line_assembler (beat counter, wrapped slot index, LINE_DATA register).
// TESTING
//  Reset then FQ_EMPTY=1 for 10 cycles -> FQ_POP, MEM_REQ_VALID, LINE_VALID, BUSY stay 0.
//  FQ_ADDR=0x0000_1044, READY=1, beats A0..A3 -> LINE_ADDR=0x0000_1040,
//   LINE_DATA={A3,A2,A1,A0}; with _EN MEM_REQ_ADDR=0x1044, beats land in slots 1,2,3,0.
//  MEM_REQ_READY low 5 cycles -> MEM_REQ_VALID and MEM_REQ_ADDR held stable, no FQ_POP.
//  LINE_READY low 4 cycles with queue non-empty -> line stable, FQ_POP stays 0 until IDLE.
//  MEM_RD_VALID pulsed in IDLE and REQ -> ignored; line later contains only COLLECT beats.
//  RST asserted after 2 of 4 beats -> IDLE next cycle, remaining 2 beats ignored, BUSY=0.

Source files
------------

// File: rtl/l2_fetch_responder_pkg.sv
// Shared FSM encoding, default geometry and address-width helpers for the L2 fetch responder.
// The optional build flag CRITICAL_WORD_FIRST_EN is consumed by l2_fetch_responder.
package l2_fetch_responder_pkg;

    localparam int ADDR_WIDTH_DFLT = 32;
    localparam int DATA_WIDTH_DFLT = 32;
    localparam int BEATS_DFLT      = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_COLLECT = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    function automatic int line_width(input int dw, input int beats);
        return dw * beats;
    endfunction

    // log2 of the line size in bytes
    function automatic int offset_bits(input int dw, input int beats);
        return $clog2(beats * dw / 8);
    endfunction

    function automatic int word_bits(input int dw);
        return $clog2(dw / 8);
    endfunction

    function automatic int beat_idx_bits(input int beats);
        return $clog2(beats);
    endfunction

endpackage

// File: rtl/l2_fetch_responder_line_assembler.sv
// Collects read-return beats into a line register; the write slot is the starting
// beat index plus the running beat count, wrapping modulo BEATS.
module l2_fetch_responder_line_assembler
    import l2_fetch_responder_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DFLT,
    parameter int BEATS      = BEATS_DFLT
) (
    input  logic                                     CLK,
    input  logic                                     RST,
    input  logic                                     start_load,
    input  logic [beat_idx_bits(BEATS)-1:0]          start_idx,
    input  logic                                     beat_en,
    input  logic [DATA_WIDTH-1:0]                    beat_data,
    output logic                                     last_beat,
    output logic [line_width(DATA_WIDTH, BEATS)-1:0] line_data
);
    localparam int IDX_BITS = beat_idx_bits(BEATS);

    logic [IDX_BITS-1:0]                cnt_q;
    logic [IDX_BITS-1:0]                start_q;
    logic [IDX_BITS-1:0]                slot;
    logic [BEATS-1:0][DATA_WIDTH-1:0]   line_q;

    // Natural truncation of the sum provides the modulo-BEATS wrap.
    assign slot      = start_q + cnt_q;
    assign last_beat = beat_en && (cnt_q == IDX_BITS'(BEATS - 1));
    assign line_data = line_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q   <= '0;
            start_q <= '0;
            line_q  <= '0;
        end else if (start_load) begin
            cnt_q   <= '0;
            start_q <= start_idx;
        end else if (beat_en) begin
            line_q[slot] <= beat_data;
            cnt_q        <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/l2_fetch_responder.sv
// Instruction-fetch miss responder: pops a PC, issues one line read, assembles the line, returns it to L1.
// Build flag CRITICAL_WORD_FIRST_EN: request the word-aligned PC and accept wrapped beat order.
//
//  state      | meaning
//  -----------+----------------------------------------------------------
//  ST_IDLE    | waiting for a fetch-queue entry; pops it when present
//  ST_REQ     | line read request presented, waiting for MEM_REQ_READY
//  ST_COLLECT | receiving BEATS return beats into the line register
//  ST_RESP    | line presented to L1, waiting for LINE_READY
module l2_fetch_responder
    import l2_fetch_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DFLT,
    parameter int DATA_WIDTH = DATA_WIDTH_DFLT,
    parameter int BEATS      = BEATS_DFLT
) (
    input  logic                                     CLK,
    input  logic                                     RST,
    input  logic                                     FQ_EMPTY,
    input  logic [ADDR_WIDTH-1:0]                    FQ_ADDR,
    output logic                                     FQ_POP,
    output logic                                     MEM_REQ_VALID,
    input  logic                                     MEM_REQ_READY,
    output logic [ADDR_WIDTH-1:0]                    MEM_REQ_ADDR,
    input  logic                                     MEM_RD_VALID,
    input  logic [DATA_WIDTH-1:0]                    MEM_RD_DATA,
    output logic                                     LINE_VALID,
    input  logic                                     LINE_READY,
    output logic [ADDR_WIDTH-1:0]                    LINE_ADDR,
    output logic [line_width(DATA_WIDTH, BEATS)-1:0] LINE_DATA,
    output logic                                     BUSY
);
    localparam int IDX_BITS = beat_idx_bits(BEATS);
    localparam int OFF_BITS = offset_bits(DATA_WIDTH, BEATS);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
        ~((ADDR_WIDTH'(1) << OFF_BITS) - ADDR_WIDTH'(1));

    state_t                  state_q;
    state_t                  state_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    pop;
    logic                    beat_en;
    logic                    last_beat;
    logic [IDX_BITS-1:0]     start_idx;

`ifdef CRITICAL_WORD_FIRST_EN
    localparam int WRD_BITS = word_bits(DATA_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK =
        ~((ADDR_WIDTH'(1) << WRD_BITS) - ADDR_WIDTH'(1));
    assign start_idx    = FQ_ADDR[WRD_BITS +: IDX_BITS];
    assign MEM_REQ_ADDR = addr_q & WORD_MASK;
`else
    assign start_idx    = '0;
    assign MEM_REQ_ADDR = addr_q & LINE_MASK;
`endif

    assign LINE_ADDR = addr_q & LINE_MASK;
    assign FQ_POP    = pop;
    assign BUSY      = (state_q != ST_IDLE);
    assign beat_en   = (state_q == ST_COLLECT) && MEM_RD_VALID;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            if (pop) begin
                addr_q <= FQ_ADDR;
            end
        end
    end

    // Pop is masked during reset so an entry is never consumed by a cycle that gets discarded.
    always_comb begin
        state_d       = state_q;
        pop           = 1'b0;
        MEM_REQ_VALID = 1'b0;
        LINE_VALID    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!FQ_EMPTY && !RST) begin
                    pop     = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                MEM_REQ_VALID = 1'b1;
                if (MEM_REQ_READY) begin
                    state_d = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (last_beat) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                LINE_VALID = 1'b1;
                if (LINE_READY) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    l2_fetch_responder_line_assembler #(
        .DATA_WIDTH (DATA_WIDTH),
        .BEATS      (BEATS)
    ) u_line_assembler (
        .CLK        (CLK),
        .RST        (RST),
        .start_load (pop),
        .start_idx  (start_idx),
        .beat_en    (beat_en),
        .beat_data  (MEM_RD_DATA),
        .last_beat  (last_beat),
        .line_data  (LINE_DATA)
    );

endmodule

// File: tb/tb_l2_fetch_responder.sv
// Scoreboard bench for l2_fetch_responder: a fetch-queue/memory model drives random traffic,
// expected request addresses and lines are queued at issue time and checked by a monitor.
module tb_l2_fetch_responder;
    localparam int AW         = 32;
    localparam int DW         = 32;
    localparam int BEATS      = 4;
    localparam int LW         = DW * BEATS;
    localparam int WB         = DW / 8;
    localparam int LINE_BYTES = WB * BEATS;

    logic          CLK           = 1'b0;
    logic          RST           = 1'b1;
    logic          FQ_EMPTY      = 1'b1;
    logic [AW-1:0] FQ_ADDR       = '0;
    logic          FQ_POP;
    logic          MEM_REQ_VALID;
    logic          MEM_REQ_READY = 1'b0;
    logic [AW-1:0] MEM_REQ_ADDR;
    logic          MEM_RD_VALID  = 1'b0;
    logic [DW-1:0] MEM_RD_DATA   = '0;
    logic          LINE_VALID;
    logic          LINE_READY    = 1'b0;
    logic [AW-1:0] LINE_ADDR;
    logic [LW-1:0] LINE_DATA;
    logic          BUSY;

    l2_fetch_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BEATS(BEATS)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .FQ_EMPTY      (FQ_EMPTY),
        .FQ_ADDR       (FQ_ADDR),
        .FQ_POP        (FQ_POP),
        .MEM_REQ_VALID (MEM_REQ_VALID),
        .MEM_REQ_READY (MEM_REQ_READY),
        .MEM_REQ_ADDR  (MEM_REQ_ADDR),
        .MEM_RD_VALID  (MEM_RD_VALID),
        .MEM_RD_DATA   (MEM_RD_DATA),
        .LINE_VALID    (LINE_VALID),
        .LINE_READY    (LINE_READY),
        .LINE_ADDR     (LINE_ADDR),
        .LINE_DATA     (LINE_DATA),
        .BUSY          (BUSY)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    logic [AW-1:0] fq[$];
    logic [AW-1:0] exp_req[$];
    logic [AW-1:0] exp_laddr[$];
    logic [LW-1:0] exp_ldata[$];

    int p_req_rdy  = 100;
    int p_line_rdy = 100;
    int p_beat     = 100;
    int p_stray    = 0;

    int            beats_left = 0;
    int            beat_i     = 0;
    logic [AW-1:0] cur_req    = '0;

    // Memory contents: a fixed scramble of the byte address.
    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [AW-1:0] line_base(input logic [AW-1:0] a);
        return a - (a % LINE_BYTES);
    endfunction

    // Memory returns beats starting at the requested word, wrapping within the line.
    function automatic logic [DW-1:0] beat_word();
        int unsigned w0;
        int unsigned widx;
        w0   = (cur_req / WB) % BEATS;
        widx = (w0 + beat_i) % BEATS;
        return mem_word(line_base(cur_req) + AW'(widx * WB));
    endfunction

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event occurred unexpectedly or time bound expired", name);
    endtask

    task automatic push_addr(input logic [AW-1:0] a);
        logic [LW-1:0] d;
        fq.push_back(a);
`ifdef CRITICAL_WORD_FIRST_EN
        exp_req.push_back(a - (a % WB));
`else
        exp_req.push_back(line_base(a));
`endif
        exp_laddr.push_back(line_base(a));
        for (int k = 0; k < BEATS; k++) d[k*DW +: DW] = mem_word(line_base(a) + AW'(k * WB));
        exp_ldata.push_back(d);
    endtask

    // One clock: drive inputs on the falling edge, then advance the queue/memory model.
    task automatic step();
        bit real_beat;
        @(negedge CLK);
        FQ_EMPTY      = (fq.size() == 0);
        FQ_ADDR       = (fq.size() != 0) ? fq[0] : AW'($urandom);
        MEM_REQ_READY = (int'($urandom_range(99)) < p_req_rdy);
        LINE_READY    = (int'($urandom_range(99)) < p_line_rdy);
        real_beat     = 1'b0;
        if (beats_left > 0) begin
            real_beat    = (int'($urandom_range(99)) < p_beat);
            MEM_RD_VALID = real_beat;
            MEM_RD_DATA  = real_beat ? beat_word() : '0;
        end else begin
            MEM_RD_VALID = (int'($urandom_range(99)) < p_stray);
            MEM_RD_DATA  = DW'($urandom);
        end
        #1;
        if (real_beat) begin
            beats_left--;
            beat_i++;
        end
        if (!RST) begin
            if (FQ_POP && fq.size() != 0) void'(fq.pop_front());
            if (MEM_REQ_VALID && MEM_REQ_READY) begin
                beats_left = BEATS;
                beat_i     = 0;
                cur_req    = MEM_REQ_ADDR;
            end
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((fq.size() != 0 || exp_laddr.size() != 0 || BUSY) && n < 3000) begin
            step();
            n++;
        end
        if (n >= 3000) fail_now("idle_timeout");
    endtask

    // Monitor: compares handshakes against the scoreboard and checks hold/latency rules.
    logic          held_line = 1'b0;
    logic          held_req  = 1'b0;
    logic          prev_pop  = 1'b0;
    logic [AW-1:0] h_laddr   = '0;
    logic [AW-1:0] h_raddr   = '0;
    logic [LW-1:0] h_ldata   = '0;

    always @(negedge CLK) begin
        #2;
        if (RST) begin
            held_line = 1'b0;
            held_req  = 1'b0;
            prev_pop  = 1'b0;
        end else begin
            if (prev_pop) check("req_latency", LW'(MEM_REQ_VALID), LW'(1'b1));
            if (held_req) begin
                check("req_hold_valid", LW'(MEM_REQ_VALID), LW'(1'b1));
                check("req_hold_addr", LW'(MEM_REQ_ADDR), LW'(h_raddr));
            end
            if (held_line) begin
                check("line_hold_valid", LW'(LINE_VALID), LW'(1'b1));
                check("line_hold_addr", LW'(LINE_ADDR), LW'(h_laddr));
                check("line_hold_data", LINE_DATA, h_ldata);
            end
            if (BUSY) check("no_pop_busy", LW'(FQ_POP), LW'(1'b0));
            if (MEM_REQ_VALID && MEM_REQ_READY) begin
                if (exp_req.size() == 0) fail_now("req_unexpected");
                else check("req_addr", LW'(MEM_REQ_ADDR), LW'(exp_req.pop_front()));
            end
            if (LINE_VALID && LINE_READY) begin
                if (exp_laddr.size() == 0) fail_now("line_unexpected");
                else begin
                    check("line_addr", LW'(LINE_ADDR), LW'(exp_laddr.pop_front()));
                    check("line_data", LINE_DATA, exp_ldata.pop_front());
                end
            end
            held_req  = MEM_REQ_VALID && !MEM_REQ_READY;
            h_raddr   = MEM_REQ_ADDR;
            held_line = LINE_VALID && !LINE_READY;
            h_laddr   = LINE_ADDR;
            h_ldata   = LINE_DATA;
            prev_pop  = FQ_POP;
        end
    end

    initial begin
        int n;
        // Reset values
        repeat (3) step();
        check("rst_pop", LW'(FQ_POP), LW'(1'b0));
        check("rst_req_valid", LW'(MEM_REQ_VALID), LW'(1'b0));
        check("rst_line_valid", LW'(LINE_VALID), LW'(1'b0));
        check("rst_busy", LW'(BUSY), LW'(1'b0));
        check("rst_req_addr", LW'(MEM_REQ_ADDR), LW'(0));
        check("rst_line_addr", LW'(LINE_ADDR), LW'(0));
        check("rst_line_data", LINE_DATA, LW'(0));
        RST = 1'b0;

        // Empty queue with stray beats: nothing moves
        p_stray = 100;
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_pop", LW'(FQ_POP), LW'(1'b0));
            check("idle_req_valid", LW'(MEM_REQ_VALID), LW'(1'b0));
            check("idle_line_valid", LW'(LINE_VALID), LW'(1'b0));
            check("idle_busy", LW'(BUSY), LW'(1'b0));
            check("idle_line_data", LINE_DATA, LW'(0));
        end
        p_stray = 0;

        // Basic line, unaligned PC
        push_addr(32'h0000_1044);
        wait_idle();

        // Request backpressure with a second entry waiting
        p_req_rdy = 0;
        push_addr(32'h0000_2008);
        push_addr(32'h0000_301C);
        repeat (6) step();
        p_req_rdy = 100;
        wait_idle();

        // Line backpressure with the queue non-empty
        p_line_rdy = 0;
        push_addr(32'h0000_4000);
        push_addr(32'h0000_50FC);
        n = 0;
        while (!LINE_VALID && n < 200) begin
            step();
            n++;
        end
        if (!LINE_VALID) fail_now("line_wait_timeout");
        repeat (4) step();
        p_line_rdy = 100;
        wait_idle();

        // Stray beats in IDLE/REQ/RESP
        p_stray   = 100;
        p_req_rdy = 40;
        push_addr(32'h0000_6004);
        push_addr(32'h0000_6038);
        wait_idle();

        // Random traffic
        for (int it = 0; it < 120; it++) begin
            p_req_rdy  = int'($urandom_range(100, 20));
            p_line_rdy = int'($urandom_range(100, 20));
            p_beat     = int'($urandom_range(100, 30));
            p_stray    = int'($urandom_range(50, 0));
            for (int j = 0; j < int'($urandom_range(3, 1)); j++) push_addr(AW'($urandom));
            repeat ($urandom_range(20, 0)) step();
        end
        wait_idle();

        // Reset after two of four beats
        p_req_rdy = 100; p_line_rdy = 100; p_beat = 100; p_stray = 0;
        push_addr(32'h0000_7048);
        n = 0;
        while (beats_left != 2 && n < 100) begin
            step();
            n++;
        end
        if (beats_left != 2) fail_now("beat_wait_timeout");
        p_beat = 0;
        step();
        RST    = 1'b1;
        p_beat = 100;
        step();
        RST = 1'b0;
        check("midrst_busy", LW'(BUSY), LW'(1'b0));
        check("midrst_line_valid", LW'(LINE_VALID), LW'(1'b0));
        step();
        check("stale_busy", LW'(BUSY), LW'(1'b0));
        check("stale_line_data", LINE_DATA, LW'(0));
        exp_req.delete();
        exp_laddr.delete();
        exp_ldata.delete();
        fq.delete();
        push_addr(32'h0000_8014);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
